// File: rtl/freq_meter.sv
// Measures the period of an asynchronous divided clock in clk_in cycles and tracks lock.
// Optional glitch filter on the synchronized input: define FREQ_METER_GLITCH_FILTER_EN.
module freq_meter #(
    parameter int unsigned INPUT_CLK_FREQ    = 25000,
    parameter int unsigned EXPECTED_CLK_FREQ = 64,
    parameter int unsigned TOL_CYCLES        = 20,
    parameter int unsigned LOCK_COUNT        = 4,
    localparam int unsigned NOMINAL = INPUT_CLK_FREQ / EXPECTED_CLK_FREQ,
    localparam int unsigned PW      = $clog2(2 * NOMINAL + 1)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          sig_in,
    output logic [PW-1:0] period_out,
    output logic          period_valid,
    input  logic          period_ready,
    output logic          locked,
    output logic          timeout,
    output logic          overrun
);

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam logic [PW-1:0] CNT_MAX = PW'(2 * NOMINAL);
    localparam logic [PW-1:0] CNT_ONE = PW'(1);
    localparam logic [GW-1:0] LOCK_CNT = GW'(LOCK_COUNT);
    localparam logic [GW-1:0] GOOD_ONE = GW'(1);
    localparam int unsigned TOL_LO =
        (NOMINAL > TOL_CYCLES) ? (NOMINAL - TOL_CYCLES) : 0;
    localparam int unsigned TOL_HI = NOMINAL + TOL_CYCLES;

    typedef enum logic [1:0] {
        S_SEEK    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOST    = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt_nxt;
    logic          w_done;
    logic          w_tmo;
    logic          w_rise;
    logic          w_in_tol;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;

    logic [PW-1:0] r_period;
    logic          r_valid;
    logic          r_overrun;
    logic          r_timeout;
    logic          r_locked;
    logic [GW-1:0] r_good;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

`ifdef FREQ_METER_GLITCH_FILTER_EN
    // r_filt only follows a level seen on two consecutive synchronized samples
    logic r_filt;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_filt <= 1'b0;
        end else if (r_sync2 == r_sync3) begin
            r_filt <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & r_sync3 & ~r_filt;
`else
    assign w_rise = r_sync2 & ~r_sync3;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= S_SEEK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_SEEK: begin
                if (w_rise) begin
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    w_done    = 1'b1;
                    w_cnt_nxt = CNT_ONE;
                end else if (r_cnt == CNT_MAX) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_LOST;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            S_LOST: begin
                if (w_rise) begin
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = S_MEASURE;
                end
            end
            default: begin
                w_state_nxt = S_SEEK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_in_tol = (32'(r_cnt) >= TOL_LO) && (32'(r_cnt) <= TOL_HI);

    // A newer period always replaces an unconsumed one
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_done) begin
            r_period <= r_cnt;
            r_valid  <= 1'b1;
            if (r_valid && !period_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && period_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_good    <= '0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_tmo) begin
            r_good    <= '0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b1;
        end else if (w_done) begin
            if (w_in_tol) begin
                if (r_good != LOCK_CNT) begin
                    r_good <= r_good + GOOD_ONE;
                end
                if (r_good >= LOCK_CNT - GOOD_ONE) begin
                    r_locked <= 1'b1;
                end
            end else begin
                r_good   <= '0;
                r_locked <= 1'b0;
            end
        end
    end

    assign period_out   = r_period;
    assign period_valid = r_valid;
    assign overrun      = r_overrun;
    assign timeout      = r_timeout;
    assign locked       = r_locked;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: scoreboard of expected periods popped on handshake.
// Glitch pulse step is active only when FREQ_METER_GLITCH_FILTER_EN is defined.
module tb_freq_meter;

    localparam int NOM = 25000 / 64;
    localparam int PW  = $clog2(2 * NOM + 1);

    logic          clk_in = 1'b0;
    logic          reset;
    logic          sig_in;
    logic [PW-1:0] period_out;
    logic          period_valid;
    logic          period_ready;
    logic          locked;
    logic          timeout;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int last_n = 0;
    logic seen_valid;

    freq_meter dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .locked       (locked),
        .timeout      (timeout),
        .overrun      (overrun)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        seen_valid = seen_valid | period_valid;
    endtask

    // One sig_in period of n cycles; meas pushes the previous period,
    // which this rise completes.
    task automatic pulse(input int n, input bit meas);
        if (meas) exp_q.push_back(last_n);
        last_n = n;
        sig_in = 1'b1;
        repeat (n / 2) tick();
        sig_in = 1'b0;
        repeat (n - n / 2) tick();
    endtask

`ifdef FREQ_METER_GLITCH_FILTER_EN
    task automatic pulse_glitch(input int n, input bit meas);
        if (meas) exp_q.push_back(last_n);
        last_n = n;
        sig_in = 1'b1;
        repeat (n / 2) tick();
        sig_in = 1'b0;
        repeat (n / 4) tick();
        sig_in = 1'b1;
        tick();
        sig_in = 1'b0;
        repeat (n - n / 2 - n / 4 - 1) tick();
    endtask
`endif

    always @(negedge clk_in) begin
        if (!reset && period_valid && period_ready) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_period: observed %0d expected none",
                       period_out);
            end
            if (exp_q.size() > 0) begin
                int e;
                e = exp_q.pop_front();
                n_cmp++;
                assert (32'(period_out) === e) else begin
                    n_err++;
                    $error("FAIL period_out: observed %0d expected %0d",
                           period_out, e);
                end
            end
        end
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        sig_in       = 1'b0;
        period_ready = 1'b1;
        seen_valid   = 1'b0;
        repeat (3) tick();
        chk("rst_period", 32'(period_out), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        repeat (5) tick();

        pulse(390, 1'b0);
        repeat (3) pulse(390, 1'b1);
        chk("lock_after3", 32'(locked), 0);
        pulse(390, 1'b1);
        chk("lock_after4", 32'(locked), 1);

        pulse(420, 1'b1);
        chk("lock_before420", 32'(locked), 1);
        chk("no_timeout", 32'(timeout), 0);
        pulse(390, 1'b1);
        chk("unlock_420", 32'(locked), 0);
        repeat (3) pulse(390, 1'b1);
        chk("relock_after3", 32'(locked), 0);
        pulse(390, 1'b1);
        chk("relock_after4", 32'(locked), 1);

        pulse(800, 1'b1);
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_unlock", 32'(locked), 0);
        pulse(390, 1'b0);
        chk("lost_no_valid", 32'(period_valid), 0);
        pulse(390, 1'b1);
        chk("timeout_sticky", 32'(timeout), 1);

        period_ready = 1'b0;
        pulse(385, 1'b0);
        chk("bp_valid1", 32'(period_valid), 1);
        chk("bp_no_overrun", 32'(overrun), 0);
        pulse(390, 1'b1);
        chk("bp_valid2", 32'(period_valid), 1);
        chk("bp_overrun", 32'(overrun), 1);
        chk("bp_latest", 32'(period_out), 385);
        period_ready = 1'b1;
        pulse(390, 1'b1);
        chk("overrun_sticky", 32'(overrun), 1);

        exp_q.push_back(last_n);
        sig_in = 1'b1;
        repeat (100) tick();
        sig_in = 1'b0;
        repeat (100) tick();
        chk("pre_rst_locked", 32'(locked), 1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("mid_rst_period", 32'(period_out), 0);
        chk("mid_rst_valid", 32'(period_valid), 0);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_timeout", 32'(timeout), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);

        seen_valid = 1'b0;
        pulse(390, 1'b0);
        chk("first_rise_no_meas", 32'(seen_valid), 0);
`ifdef FREQ_METER_GLITCH_FILTER_EN
        pulse_glitch(390, 1'b1);
`else
        pulse(390, 1'b1);
`endif
        pulse(390, 1'b1);
        repeat (20) tick();
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("final_valid", 32'(period_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter INPUT_CLK_FREQ, default 25000, sets the clk_in frequency in the team's frequency units.
REQ-002 Parameter EXPECTED_CLK_FREQ, default 64, sets the nominal frequency of sig_in; NOMINAL = INPUT_CLK_FREQ/EXPECTED_CLK_FREQ (integer, 390 at defaults).
REQ-003 Parameter TOL_CYCLES, default 20, is the allowed |period - NOMINAL| for an in-tolerance period.
REQ-004 Parameter LOCK_COUNT, default 4, is the number of consecutive in-tolerance periods required to assert lock.
REQ-005 clk_in  input  1  is the single clock; all logic is on its rising edge.
REQ-006 reset  input  1  is the reset: synchronous, active-high.
REQ-007 sig_in  input  1  is the asynchronous divided clock under measurement.
REQ-008 period_out  output  PW  is the measured period in clk_in cycles; PW = $clog2(2*NOMINAL+1).
REQ-009 period_valid  output  1  marks period_out as valid.
REQ-010 period_ready  input  1  is the consumer's acceptance of the measurement.
REQ-011 locked  output  1  indicates sig_in is stable within tolerance.
REQ-012 timeout  output  1  is a sticky flag indicating no sig_in rising edge within 2*NOMINAL cycles.
REQ-013 overrun  output  1  is a sticky flag indicating a measurement was dropped due to backpressure.

Function
REQ-014 sig_in SHALL pass through a 2-flop synchronizer; a rising edge (rise) SHALL be detected when the synchronized value is 1 and its previous value is 0.
REQ-015 FSM states SHALL be SEEK, MEASURE and LOST; the reset state is SEEK.
REQ-016 SEEK: on rise, the counter SHALL load 1 and the FSM SHALL go to MEASURE; no measurement is produced.
REQ-017 MEASURE: the counter SHALL increment each cycle; on rise, period = counter value, the counter SHALL reload 1, and the FSM SHALL stay in MEASURE.
REQ-018 A constant sig_in period of N clk_in cycles SHALL yield period_out = N.
REQ-019 MEASURE: when the counter reaches 2*NOMINAL without a rise, the FSM SHALL go to LOST, set timeout and clear locked.
REQ-020 LOST: the counter SHALL hold; on rise, the counter SHALL load 1 and the FSM SHALL go to MEASURE; timeout stays set.
REQ-021 A completed period SHALL load period_out and assert period_valid on the following cycle.
REQ-022 period_valid SHALL stay high until period_valid && period_ready is sampled, then drop, unless a new period arrives in that same cycle.
REQ-023 If a new period arrives while period_valid is high and period_ready is low, period_out SHALL be overwritten with the newer value and overrun SHALL set.
REQ-024 If a new period arrives while period_valid is high and period_ready is high, it SHALL be loaded with no overrun.
REQ-025 An in-tolerance period SHALL increment a consecutive-good counter that saturates at LOCK_COUNT; locked SHALL assert when the counter reaches LOCK_COUNT.
REQ-026 An out-of-tolerance period or a timeout SHALL clear the consecutive-good counter and locked in the same cycle as the period is loaded.
REQ-027 Tolerance SHALL be compared with unsigned arithmetic and no wrap: in-tolerance means NOMINAL-TOL_CYCLES <= period <= NOMINAL+TOL_CYCLES, with the low bound clamped at 0.

Reset
REQ-028 Under reset, the FSM SHALL go to SEEK, the counters and synchronizer SHALL clear, and period_out=0, period_valid=0, locked=0, timeout=0, overrun=0.
REQ-029 Reset asserted mid-measurement SHALL discard the partial count; the first rise after reset SHALL produce no measurement.
REQ-030 Reset is the only mechanism that clears the timeout and overrun flags.

Configuration
REQ-031 With FREQ_METER_GLITCH_FILTER_EN defined, a level change SHALL be accepted only after the synchronized sig_in holds the new level for 2 consecutive cycles; this adds 1 cycle of edge latency, and single-cycle pulses SHALL be ignored.
REQ-032 With FREQ_METER_GLITCH_FILTER_EN undefined, no filter SHALL be present and edge detection SHALL follow REQ-014 directly.

Verification (default parameters, filter off unless noted)
REQ-033 sig_in with period 390 cycles, period_ready=1 -> period_out=390 for every period; locked=1 after the 4th measurement.
REQ-034 Locked, then a single 420-cycle period -> locked=0 the cycle that period loads; re-lock after 4 further 390-cycle periods.
REQ-035 sig_in held low for 800 cycles while in MEASURE -> timeout=1 and locked=0 at count 780; the next two rises yield a valid measurement.
REQ-036 period_ready=0 across two 390-cycle periods -> period_valid stays 1, overrun=1, period_out holds the latest value.
REQ-037 Reset at count 200 of a period -> all outputs 0; the first rise after reset gives no period_valid.
REQ-038 With FREQ_METER_GLITCH_FILTER_EN defined, a 1-cycle sig_in high pulse mid-period -> no measurement; the period still reads 390.
